// File: rtl/blk_1d0b7a.sv
// Debug-slave memory master: turns JTAG ocimem strobes into single-word Avalon-MM reads/writes.
// Optional address auto-increment after each successful access: define DEBUG_MEM_MASTER_AUTOINC_EN.
module blk_1d0b7a #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [37:0]         jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic                take_no_action_ocimem_a,
    output logic [ADDR_W+1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    output logic [3:0]          avm_byteenable,
    input  logic [31:0]         avm_readdata,
    input  logic                avm_waitrequest,
    output logic [31:0]         MonDReg,
    output logic                monitor_ready,
    output logic                monitor_error
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        mon_dreg_q, mon_dreg_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               any_strobe;

    // jdo bits outside the address and data fields carry nothing for this block.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mon_dreg_d = mon_dreg_q;
        ready_d    = ready_q;
        error_d    = error_q;
        read_d     = read_q;
        write_d    = write_q;
        overrun_d  = overrun_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_b) begin
                    wdata_d   = jdo[34:3];
                    state_d   = ST_WR;
                    write_d   = 1'b1;
                    ready_d   = 1'b0;
                    error_d   = 1'b0;
                    overrun_d = 1'b0;
                    cnt_d     = '0;
                end else if (take_action_ocimem_a) begin
                    addr_d    = jdo[17 +: ADDR_W];
                    overrun_d = 1'b0;
                    error_d   = 1'b0;
                    if (jdo[34]) begin
                        state_d = ST_RD;
                        read_d  = 1'b1;
                        ready_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    state_d   = ST_RD;
                    read_d    = 1'b1;
                    ready_d   = 1'b0;
                    error_d   = 1'b0;
                    overrun_d = 1'b0;
                    cnt_d     = '0;
                end
            end

            ST_RD, ST_WR: begin
                if (any_strobe) begin
                    overrun_d = 1'b1;
                end
                // Waitrequest low on any cycle wins, even the one the timeout would fire on.
                if (!avm_waitrequest) begin
                    if (state_q == ST_RD) begin
                        mon_dreg_d = avm_readdata;
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ready_d = 1'b1;
                    error_d = overrun_d;
                    state_d = ST_IDLE;
`ifdef DEBUG_MEM_MASTER_AUTOINC_EN
                    if (!overrun_d) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
`endif
                end else if (TIMEOUT_CYC > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == TIMEOUT_VAL) begin
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            mon_dreg_q <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mon_dreg_q <= mon_dreg_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            read_q     <= read_d;
            write_q    <= write_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign avm_address    = {addr_q, 2'b00};
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;
    assign MonDReg        = mon_dreg_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = error_q;

endmodule

// File: tb/tb_blk_1d0b7a.sv
// Directed bench for blk_1d0b7a; expectations follow DEBUG_MEM_MASTER_AUTOINC_EN when defined.
module tb_blk_1d0b7a;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [11:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int total;
    int bad;
    logic [9:0]  exp_addr;
    logic [31:0] exp_mon;

`ifdef DEBUG_MEM_MASTER_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    blk_1d0b7a #(.ADDR_W(10), .TIMEOUT_CYC(255)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_addr(input logic [9:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[17 +: 10] = a;
        j[34] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        jdo = jdo_addr(10'h3AA, 1'b1);
        for (int i = 0; i < 4; i++) begin
            take_action_ocimem_a    = i[0];
            take_action_ocimem_b    = i[1];
            take_no_action_ocimem_a = ~i[0];
            tick();
            total++;
            if ((avm_read | avm_write) !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_req cyc=%0d got rd=%b wr=%b want 0", i, avm_read, avm_write);
            end
        end
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
        total++;
        if ({avm_address, avm_writedata, MonDReg, monitor_ready, monitor_error} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outs got addr=%h wd=%h mon=%h rdy=%b err=%b want all 0",
                     avm_address, avm_writedata, MonDReg, monitor_ready, monitor_error);
        end
        total++;
        if (avm_byteenable !== 4'hF) begin
            bad++;
            $display("[TB] FAIL reset_be got %h want f", avm_byteenable);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        avm_waitrequest = 1'b0;
        avm_readdata = 32'hDEADBEEF;
        jdo = jdo_addr(10'h040, 1'b1);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        total++;
        if (avm_read !== 1'b1 || avm_address !== 12'h100 || monitor_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL read_req got rd=%b addr=%h rdy=%b want 1 100 0", avm_read, avm_address, monitor_ready);
        end
        tick();
        exp_mon = 32'hDEADBEEF;
        exp_addr = AUTOINC ? 10'h041 : 10'h040;
        total++;
        if (avm_read !== 1'b0 || MonDReg !== exp_mon || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin
            bad++;
            $display("[TB] FAIL read_done got rd=%b mon=%h rdy=%b err=%b want 0 %h 1 0",
                     avm_read, MonDReg, monitor_ready, monitor_error, exp_mon);
        end
        total++;
        if (avm_address !== {exp_addr, 2'b00}) begin
            bad++;
            $display("[TB] FAIL read_addr got %h want %h", avm_address, {exp_addr, 2'b00});
        end
    endtask

    task automatic test_addr_load();
        jdo = jdo_addr(10'h155, 1'b0);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        exp_addr = 10'h155;
        total++;
        if (avm_read !== 1'b0 || avm_address !== 12'h554 || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin
            bad++;
            $display("[TB] FAIL addr_load got rd=%b addr=%h rdy=%b err=%b want 0 554 1 0",
                     avm_read, avm_address, monitor_ready, monitor_error);
        end
    endtask

    task automatic test_write();
        avm_waitrequest = 1'b1;
        jdo = jdo_data(32'h12345678);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (avm_write !== 1'b1 || avm_writedata !== 32'h12345678 || avm_address !== 12'h554 || monitor_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL write_hold cyc=%0d got wr=%b wd=%h addr=%h rdy=%b want 1 12345678 554 0",
                         i, avm_write, avm_writedata, avm_address, monitor_ready);
            end
            if (i == 4) avm_waitrequest = 1'b0;
            tick();
        end
        exp_addr = AUTOINC ? 10'h156 : 10'h155;
        total++;
        if (avm_write !== 1'b0 || monitor_ready !== 1'b1 || monitor_error !== 1'b0 || avm_address !== {exp_addr, 2'b00}) begin
            bad++;
            $display("[TB] FAIL write_done got wr=%b rdy=%b err=%b addr=%h want 0 1 0 %h",
                     avm_write, monitor_ready, monitor_error, avm_address, {exp_addr, 2'b00});
        end
    endtask

    task automatic test_timeout();
        int n;
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h11112222;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        total++;
        if (avm_read !== 1'b1 || avm_address !== {exp_addr, 2'b00}) begin
            bad++;
            $display("[TB] FAIL tmo_req got rd=%b addr=%h want 1 %h", avm_read, avm_address, {exp_addr, 2'b00});
        end
        n = 0;
        while (avm_read === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        total++;
        if (n !== 255) begin
            bad++;
            $display("[TB] FAIL tmo_len got %0d stalled request cycles want 255", n);
        end
        total++;
        if (monitor_ready !== 1'b1 || monitor_error !== 1'b1 || MonDReg !== exp_mon || avm_address !== {exp_addr, 2'b00}) begin
            bad++;
            $display("[TB] FAIL tmo_done got rdy=%b err=%b mon=%h addr=%h want 1 1 %h %h",
                     monitor_ready, monitor_error, MonDReg, avm_address, exp_mon, {exp_addr, 2'b00});
        end
        avm_waitrequest = 1'b0;
    endtask

    task automatic test_back_to_back();
        jdo = jdo_addr(10'h2A0, 1'b0);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        exp_addr = 10'h2A0;
        avm_waitrequest = 1'b1;
        jdo = jdo_data(32'hCAFEF00D);
        take_action_ocimem_b = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        total++;
        if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_writedata !== 32'hCAFEF00D) begin
            bad++;
            $display("[TB] FAIL b2b_prio got wr=%b rd=%b wd=%h want 1 0 cafef00d", avm_write, avm_read, avm_writedata);
        end
        jdo = jdo_data(32'h0000FFFF);
        tick();
        take_action_ocimem_b = 1'b0;
        total++;
        if (avm_write !== 1'b1 || avm_writedata !== 32'hCAFEF00D || monitor_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_ignore got wr=%b wd=%h rdy=%b want 1 cafef00d 0", avm_write, avm_writedata, monitor_ready);
        end
        avm_waitrequest = 1'b0;
        tick();
        total++;
        if (avm_write !== 1'b0 || monitor_ready !== 1'b1 || monitor_error !== 1'b1 || avm_address !== {exp_addr, 2'b00}) begin
            bad++;
            $display("[TB] FAIL b2b_overrun got wr=%b rdy=%b err=%b addr=%h want 0 1 1 %h",
                     avm_write, monitor_ready, monitor_error, avm_address, {exp_addr, 2'b00});
        end
        avm_readdata = 32'h0BADF00D;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        tick();
        exp_mon = 32'h0BADF00D;
        exp_addr = AUTOINC ? 10'h2A1 : 10'h2A0;
        total++;
        if (monitor_ready !== 1'b1 || monitor_error !== 1'b0 || MonDReg !== exp_mon || avm_address !== {exp_addr, 2'b00}) begin
            bad++;
            $display("[TB] FAIL b2b_clear got rdy=%b err=%b mon=%h addr=%h want 1 0 %h %h",
                     monitor_ready, monitor_error, MonDReg, avm_address, exp_mon, {exp_addr, 2'b00});
        end
    endtask

    task automatic test_wrap();
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h55AA55AA;
        jdo = jdo_addr(10'h3FF, 1'b1);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        total++;
        if (avm_read !== 1'b1 || avm_address !== 12'hFFC) begin
            bad++;
            $display("[TB] FAIL wrap_req got rd=%b addr=%h want 1 ffc", avm_read, avm_address);
        end
        tick();
        exp_addr = AUTOINC ? 10'h000 : 10'h3FF;
        total++;
        if (MonDReg !== 32'h55AA55AA || monitor_error !== 1'b0 || avm_address !== {exp_addr, 2'b00}) begin
            bad++;
            $display("[TB] FAIL wrap_done got mon=%h err=%b addr=%h want 55aa55aa 0 %h",
                     MonDReg, monitor_error, avm_address, {exp_addr, 2'b00});
        end
    endtask

    task automatic test_reset_mid();
        avm_waitrequest = 1'b1;
        jdo = jdo_addr(10'h010, 1'b1);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        total++;
        if (avm_read !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_req got rd=%b want 1", avm_read);
        end
        reset_n = 1'b0;
        avm_waitrequest = 1'b0;
        tick();
        reset_n = 1'b1;
        total++;
        if (avm_read !== 1'b0 || monitor_ready !== 1'b0 || avm_address !== 12'h000 || MonDReg !== 32'h0) begin
            bad++;
            $display("[TB] FAIL mid_reset got rd=%b rdy=%b addr=%h mon=%h want 0 0 000 0",
                     avm_read, monitor_ready, avm_address, MonDReg);
        end
        tick();
        total++;
        if (avm_read !== 1'b0 || monitor_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_after got rd=%b rdy=%b want 0 0", avm_read, monitor_ready);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avm_readdata = '0;
        avm_waitrequest = 1'b0;
        exp_addr = '0;
        exp_mon = '0;
        #1;
        test_reset();
        test_read();
        test_addr_load();
        test_write();
        test_timeout();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
